// File: rtl/tick_arbiter.sv
// ---------------------------------------------------------------------------
// tick_arbiter
// Round-robin scheduler that lends one periodic tick engine to NREQ
// requesters. The winner gets burst_len ticks spaced PERIOD cycles apart,
// then the engine is released for one arbitration cycle before the next
// requester is served.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req        per-requester request level, held until its done
//   burst_len  ticks per burst, sampled at grant (0 behaves as 1)
//   gnt        registered one-hot grant, high for the whole burst
//   tick       registered tick pulse to the shared consumer
//   done       one-cycle pulse in the final cycle of a burst
//   busy       high while a burst runs (|gnt)
// ---------------------------------------------------------------------------
module tick_arbiter #(
   parameter int NREQ   = 4,
   parameter int PERIOD = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [CNT_W-1:0] burst_len,
   output logic [NREQ-1:0]  gnt,
   output logic             tick,
   output logic             done,
   output logic             busy
);

   localparam int OWN_W = (NREQ   > 1) ? $clog2(NREQ)   : 1;
   localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [OWN_W-1:0] ptr;
   logic [OWN_W-1:0] owner;
   logic [PH_W-1:0]  phase;
   logic [CNT_W-1:0] remain;

   logic [OWN_W-1:0] pick;
   logic             found;
   int               idx;
   logic [PH_W-1:0]  phase_nxt;
   logic [OWN_W-1:0] next_ptr;

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = OWN_W'(idx);
         end
      end
   end

   assign phase_nxt = (phase == PH_W'(PERIOD - 1)) ? '0 : phase + 1'b1;
   assign next_ptr  = (owner == OWN_W'(NREQ - 1)) ? '0 : owner + 1'b1;
   assign busy      = |gnt;

   // NOTE: state is updated with non-blocking assignments so every branch sees
   // the pre-edge values of phase/remain/owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         owner  <= '0;
         phase  <= '0;
         remain <= '0;
         gnt    <= '0;
         tick   <= 1'b0;
         done   <= 1'b0;
      end else begin
         tick <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt    <= NREQ'(1) << pick;
                  owner  <= pick;
                  tick   <= 1'b1;
                  phase  <= '0;
                  remain <= (burst_len == '0) ? CNT_W'(1) : burst_len;
                  state  <= RUN;
               end
            end
            RUN: begin
               // Leave after the done cycle, or at once if the owner drops
               // its request (abort: no done is produced).
               if (done || !req[owner]) begin
                  gnt   <= '0;
                  ptr   <= next_ptr;
                  state <= IDLE;
               end else begin
                  phase <= phase_nxt;
                  // The last tick leaves remain at 1; it then just counts
                  // out the final period before done.
                  if (phase_nxt == '0 && remain > CNT_W'(1)) begin
                     tick   <= 1'b1;
                     remain <= remain - 1'b1;
                  end
                  if (phase_nxt == PH_W'(PERIOD - 1) && remain == CNT_W'(1))
                     done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tick_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tick_arbiter
// Directed bench for tick_arbiter (NREQ=4, PERIOD=4, CNT_W=8). The stimulus
// process pushes the expected {gnt,tick,done,busy} for each cycle, tagged
// with its absolute cycle number, into a queue; the monitor pops and compares
// on the falling edge of that cycle.
// ---------------------------------------------------------------------------
module tb_tick_arbiter;

   localparam int NREQ   = 4;
   localparam int PERIOD = 4;
   localparam int CNT_W  = 8;

   typedef struct {
      int         cyc;
      logic [6:0] vec;   // {gnt[3:0], tick, done, busy}
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NREQ-1:0]  req;
   logic [CNT_W-1:0] burst_len;
   logic [NREQ-1:0]  gnt;
   logic             tick;
   logic             done;
   logic             busy;

   exp_t exp_q[$];
   int   cyc     = 0;
   int   n_check = 0;
   int   n_fail  = 0;

   tick_arbiter #(.NREQ(NREQ), .PERIOD(PERIOD), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .burst_len (burst_len),
      .gnt       (gnt),
      .tick      (tick),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] req_v);
      n_check++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b tick=%b done=%b busy=%b, expected gnt=%b tick=%b done=%b busy=%b",
                  name, act[6:3], act[2], act[1], act[0],
                  req_v[6:3], req_v[2], req_v[1], req_v[0]);
      end
   endtask

   // Monitor: compares every expectation tagged with the current cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc < cyc) begin
               n_check++;
               n_fail++;
               $display("FAIL missed cycle %0d: now at %0d", e.cyc, cyc);
            end else begin
               check($sformatf("cycle %0d", e.cyc), {gnt, tick, done, busy}, e.vec);
            end
         end
      end
   end

   task automatic push(input int c, input logic [3:0] g, input logic t, input logic d, input logic b);
      exp_t e;
      e.cyc = c;
      e.vec = {g, t, d, b};
      exp_q.push_back(e);
   endtask

   // Expected trace of a burst granted at edge e0: cycles 1..last carry the
   // grant; ticks at 1, 1+P, ...; done at n*P; cycle last+1 is all zero.
   task automatic push_burst(input int e0, input int own, input int n, input int last);
      logic [3:0] g;
      g = 4'b0001 << own;
      for (int c = 1; c <= last; c++)
         push(e0 + c, g, ((c - 1) % PERIOD) == 0, c == n * PERIOD, 1'b1);
      push(e0 + last + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
   endtask

   // Called in the cycle before the arbitration edge; returns in the
   // mandatory idle cycle after the burst with req cleared.
   task automatic run_burst(input logic [3:0] req_v, input int own, input int len);
      int n;
      n = (len == 0) ? 1 : len;
      req       = req_v;
      burst_len = CNT_W'(len);
      push_burst(cyc, own, n, n * PERIOD);
      repeat (n * PERIOD + 1) @(posedge clk);
      #1;
      req = '0;
   endtask

   initial begin
      int e0;

      // Reset with random requests: outputs stay low.
      rst       = 1'b1;
      req       = 4'($urandom);
      burst_len = 8'd5;
      push(1, 4'b0000, 1'b0, 1'b0, 1'b0);
      push(2, 4'b0000, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      req = '0;
      push(3, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;

      // First grant after reset goes to the lowest active index.
      run_burst(4'b1010, 1, 2);
      run_burst(4'b1000, 3, 1);
      // Single burst: len 3, ticks 1/5/9, done 12, gnt low at 13.
      run_burst(4'b0001, 0, 3);
      // Round-robin with all requesting, len 1.
      run_burst(4'b1111, 1, 1);
      run_burst(4'b1111, 2, 1);
      run_burst(4'b1111, 3, 1);
      run_burst(4'b1111, 0, 1);
      run_burst(4'b1111, 1, 1);
      // Zero length behaves as one.
      run_burst(4'b0100, 2, 0);

      // Abort: req[2] drops in cycle 6 of a 3-tick burst; index 3 is next.
      e0        = cyc;
      req       = 4'b0100;
      burst_len = 8'd3;
      push_burst(e0, 2, 3, 6);
      repeat (6) @(posedge clk);
      #1;
      req       = 4'b1000;
      burst_len = 8'd1;
      @(posedge clk);
      #1;
      run_burst(4'b1000, 3, 1);

      // Move ptr off zero, then reset in cycle 5 of a burst.
      run_burst(4'b0010, 1, 1);
      e0        = cyc;
      req       = 4'b0100;
      burst_len = 8'd3;
      push_burst(e0, 2, 3, 5);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      // ptr is back at 0, so index 1 wins over index 3.
      run_burst(4'b1010, 1, 2);

      // Maximum length runs to completion without counter wrap.
      run_burst(4'b0001, 0, 255);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_check++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule
